// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared types and constants for the RV32I decode stage.
//               Internal opcode enumeration (ILLEGAL = 0), RV32I major-opcode
//               values and funct3/funct7 field values.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

  localparam int OPC_W = 6;

  typedef enum logic [OPC_W-1:0] {
    OP_ILLEGAL = 6'd0,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_JAL, OP_JALR, OP_AUIPC, OP_LUI
  } opcode_e;

  // RV32I major opcodes (inst[6:0])
  localparam logic [6:0] MAJ_OP     = 7'h33;
  localparam logic [6:0] MAJ_OP_IMM = 7'h13;
  localparam logic [6:0] MAJ_LOAD   = 7'h03;
  localparam logic [6:0] MAJ_JALR   = 7'h67;
  localparam logic [6:0] MAJ_STORE  = 7'h23;
  localparam logic [6:0] MAJ_BRANCH = 7'h63;
  localparam logic [6:0] MAJ_JAL    = 7'h6F;
  localparam logic [6:0] MAJ_AUIPC  = 7'h17;
  localparam logic [6:0] MAJ_LUI    = 7'h37;

  // ALU funct3 (shared by register and immediate forms)
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  // Load / store / branch / jalr funct3
  localparam logic [2:0] F3_B    = 3'd0;
  localparam logic [2:0] F3_H    = 3'd1;
  localparam logic [2:0] F3_W    = 3'd2;
  localparam logic [2:0] F3_BU   = 3'd4;
  localparam logic [2:0] F3_HU   = 3'd5;
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  localparam logic [2:0] F3_JALR = 3'd0;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

endpackage
`default_nettype wire

// File: rtl/rv32i_decode_comb.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_decode_comb
// Description : Purely combinational RV32I decoder.
//               inst_i -> rs_o/rt_o/rd_o (register indices), imm_o (extended
//               immediate), opcode_o (internal opcode), illegal_o.
//               Fields a format does not use are driven to zero; an illegal
//               encoding drives every field to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_decode_comb
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [DATA_W-1:0] inst_i,
  output logic [REG_W-1:0]  rs_o,
  output logic [REG_W-1:0]  rt_o,
  output logic [REG_W-1:0]  rd_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [OPC_W-1:0]  opcode_o,
  output logic              illegal_o
);

  logic [6:0]        w_major;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic              w_alt;
  logic [DATA_W-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u, w_shamt;
  logic [DATA_W-1:0] w_imm;
  opcode_e           w_op;
  logic              w_use_rs, w_use_rt, w_use_rd;

  assign w_major = inst_i[6:0];
  assign w_f3    = inst_i[14:12];
  assign w_f7    = inst_i[31:25];
  assign w_alt   = inst_i[30];

  assign w_imm_i = DATA_W'($signed(inst_i[31:20]));
  assign w_imm_s = DATA_W'($signed({inst_i[31:25], inst_i[11:7]}));
  assign w_imm_b = DATA_W'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign w_imm_j = DATA_W'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
  assign w_imm_u = DATA_W'($signed({inst_i[31:12], 12'b0}));
  assign w_shamt = DATA_W'(inst_i[24:20]);

  always_comb begin
    w_op     = OP_ILLEGAL;
    w_imm    = '0;
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    w_use_rd = 1'b0;
    case (w_major)
      MAJ_OP: begin
        {w_use_rs, w_use_rt, w_use_rd} = 3'b111;
        // inst[30] only distinguishes ADD/SUB and SRL/SRA; other funct3
        // values accept either legal funct7.
        if (w_f7 == F7_BASE || w_f7 == F7_ALT) begin
          case (w_f3)
            F3_ADD:  w_op = w_alt ? OP_SUB : OP_ADD;
            F3_SLL:  w_op = OP_SLL;
            F3_SLT:  w_op = OP_SLT;
            F3_SLTU: w_op = OP_SLTU;
            F3_XOR:  w_op = OP_XOR;
            F3_SR:   w_op = w_alt ? OP_SRA : OP_SRL;
            F3_OR:   w_op = OP_OR;
            default: w_op = OP_AND;
          endcase
        end
      end
      MAJ_OP_IMM: begin
        {w_use_rs, w_use_rd} = 2'b11;
        w_imm = w_imm_i;
        case (w_f3)
          F3_ADD:  w_op = OP_ADDI;
          F3_SLL:  begin w_op = OP_SLLI; w_imm = w_shamt; end
          F3_SLT:  w_op = OP_SLTI;
          F3_SLTU: w_op = OP_SLTIU;
          F3_XOR:  w_op = OP_XORI;
          F3_SR:   begin w_op = w_alt ? OP_SRAI : OP_SRLI; w_imm = w_shamt; end
          F3_OR:   w_op = OP_ORI;
          default: w_op = OP_ANDI;
        endcase
      end
      MAJ_LOAD: begin
        {w_use_rs, w_use_rd} = 2'b11;
        w_imm = w_imm_i;
        case (w_f3)
          F3_B:    w_op = OP_LB;
          F3_H:    w_op = OP_LH;
          F3_W:    w_op = OP_LW;
          F3_BU:   w_op = OP_LBU;
          F3_HU:   w_op = OP_LHU;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      MAJ_JALR: begin
        {w_use_rs, w_use_rd} = 2'b11;
        w_imm = w_imm_i;
        w_op  = (w_f3 == F3_JALR) ? OP_JALR : OP_ILLEGAL;
      end
      MAJ_STORE: begin
        {w_use_rs, w_use_rt} = 2'b11;
        w_imm = w_imm_s;
        // Only byte/half/word stores exist; wider widths are rejected.
        case (w_f3)
          F3_B:    w_op = OP_SB;
          F3_H:    w_op = OP_SH;
          F3_W:    w_op = OP_SW;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      MAJ_BRANCH: begin
        {w_use_rs, w_use_rt} = 2'b11;
        w_imm = w_imm_b;
        case (w_f3)
          F3_BEQ:  w_op = OP_BEQ;
          F3_BNE:  w_op = OP_BNE;
          F3_BLT:  w_op = OP_BLT;
          F3_BGE:  w_op = OP_BGE;
          F3_BLTU: w_op = OP_BLTU;
          F3_BGEU: w_op = OP_BGEU;
          default: w_op = OP_ILLEGAL;
        endcase
      end
      MAJ_JAL:   begin w_use_rd = 1'b1; w_imm = w_imm_j; w_op = OP_JAL;   end
      MAJ_AUIPC: begin w_use_rd = 1'b1; w_imm = w_imm_u; w_op = OP_AUIPC; end
      MAJ_LUI:   begin w_use_rd = 1'b1; w_imm = w_imm_u; w_op = OP_LUI;   end
      default:   w_op = OP_ILLEGAL;
    endcase
  end

  assign illegal_o = (w_op == OP_ILLEGAL);
  assign opcode_o  = w_op;
  assign imm_o     = illegal_o ? '0 : w_imm;
  assign rs_o      = (w_use_rs && !illegal_o) ? REG_W'(inst_i[19:15]) : '0;
  assign rt_o      = (w_use_rt && !illegal_o) ? REG_W'(inst_i[24:20]) : '0;
  assign rd_o      = (w_use_rd && !illegal_o) ? REG_W'(inst_i[11:7])  : '0;

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32I decode stage between instruction queue and reservation
//               station. Decodes one instruction per cycle into an in-order
//               output FIFO of DEPTH entries; emits branch-predictor and JAL
//               redirect pulses; supports flush and global stall (rdy_in).
// Ports       : clk_in, rst_in (async, active-high), rdy_in, flush_in
//               iq_*  : valid/ready instruction input (inst, pc)
//               rs_*  : FIFO head (valid/ready, rs/rt/rd, imm, opcode, pc,
//                       illegal)
//               bp_*  : branch decoded pulse + its PC
//               if_*  : JAL redirect pulse + target address
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
  import decode_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 6,
  parameter int DEPTH  = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              iq_valid_in,
  output logic              iq_ready_out,
  input  logic [DATA_W-1:0] iq_inst_in,
  input  logic [ADDR_W-1:0] iq_pc_in,
  output logic              rs_valid_out,
  input  logic              rs_ready_in,
  output logic [REG_W-1:0]  rs_rs_out,
  output logic [REG_W-1:0]  rs_rt_out,
  output logic [REG_W-1:0]  rs_rd_out,
  output logic [DATA_W-1:0] rs_imm_out,
  output logic [OP_W-1:0]   rs_opcode_out,
  output logic [ADDR_W-1:0] rs_pc_out,
  output logic              rs_illegal_out,
  output logic              bp_en_out,
  output logic [ADDR_W-1:0] bp_pc_out,
  output logic              if_en_out,
  output logic [ADDR_W-1:0] if_addr_out
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = 3 * REG_W + DATA_W + OP_W + ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [REG_W-1:0]   w_rs, w_rt, w_rd;
  logic [DATA_W-1:0]  w_imm;
  logic [OPC_W-1:0]   w_op;
  logic               w_illegal;
  logic [ENTRY_W-1:0] w_entry;
  logic               w_push, w_pop, w_is_branch, w_is_jal;
  logic [ADDR_W-1:0]  w_jal_target;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               bp_en_q, if_en_q;
  logic [ADDR_W-1:0]  bp_pc_q, if_addr_q;

  rv32i_decode_comb #(.DATA_W(DATA_W), .REG_W(REG_W)) u_dec (
    .inst_i    (iq_inst_in),
    .rs_o      (w_rs),
    .rt_o      (w_rt),
    .rd_o      (w_rd),
    .imm_o     (w_imm),
    .opcode_o  (w_op),
    .illegal_o (w_illegal)
  );

  assign w_entry = {w_illegal, OP_W'(w_op), iq_pc_in, w_imm, w_rd, w_rt, w_rs};

  assign iq_ready_out = (count_q < CNT_W'(DEPTH));
  assign rs_valid_out = (count_q != '0);

  // Flush and freeze both suppress every FIFO action for the cycle.
  assign w_push = rdy_in & ~flush_in & iq_valid_in & iq_ready_out;
  assign w_pop  = rdy_in & ~flush_in & rs_valid_out & rs_ready_in;

  assign w_is_branch  = (iq_inst_in[6:0] == MAJ_BRANCH) & ~w_illegal;
  assign w_is_jal     = (iq_inst_in[6:0] == MAJ_JAL);
  assign w_jal_target = iq_pc_in + ADDR_W'($signed({iq_inst_in[31], iq_inst_in[19:12],
                                                     iq_inst_in[20], iq_inst_in[30:21], 1'b0}));

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (w_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    if (w_push && !w_pop)      count_d = count_q + CNT_W'(1);
    else if (!w_push && w_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        count_q  <= count_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        if (w_push) mem_q[wr_ptr_q] <= w_entry;
      end
    end
  end

  // Pulse flags self-clear on every edge; w_push already excludes freeze
  // and flush, so a pulse never repeats after a stall.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bp_en_q   <= 1'b0;
      if_en_q   <= 1'b0;
      bp_pc_q   <= '0;
      if_addr_q <= '0;
    end else begin
      bp_en_q <= w_push & w_is_branch;
      if_en_q <= w_push & w_is_jal;
      if (w_push && w_is_branch) bp_pc_q   <= iq_pc_in;
      if (w_push && w_is_jal)    if_addr_q <= w_jal_target;
    end
  end

  assign {rs_illegal_out, rs_opcode_out, rs_pc_out, rs_imm_out,
          rs_rd_out, rs_rt_out, rs_rs_out} = mem_q[rd_ptr_q];

  assign bp_en_out   = bp_en_q & rdy_in;
  assign bp_pc_out   = bp_pc_q;
  assign if_en_out   = if_en_q & rdy_in;
  assign if_addr_out = if_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage: directed scenarios with
//               literal expectations, then randomized traffic compared every
//               cycle against a behavioural queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
  import decode_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1, flush = 1'b0, iq_valid = 1'b0, rs_ready = 1'b0;
  logic [31:0] inst = '0, pc = '0;
  logic        iq_ready, rs_valid, rs_illegal, bp_en, if_en;
  logic [4:0]  rs_rs, rs_rt, rs_rd;
  logic [31:0] rs_imm, rs_pc, bp_pc, if_addr;
  logic [5:0]  rs_opcode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage #(.ADDR_W(32), .DATA_W(32), .REG_W(5), .OP_W(6), .DEPTH(DEPTH)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .iq_valid_in(iq_valid), .iq_ready_out(iq_ready), .iq_inst_in(inst), .iq_pc_in(pc),
    .rs_valid_out(rs_valid), .rs_ready_in(rs_ready),
    .rs_rs_out(rs_rs), .rs_rt_out(rs_rt), .rs_rd_out(rs_rd), .rs_imm_out(rs_imm),
    .rs_opcode_out(rs_opcode), .rs_pc_out(rs_pc), .rs_illegal_out(rs_illegal),
    .bp_en_out(bp_en), .bp_pc_out(bp_pc), .if_en_out(if_en), .if_addr_out(if_addr)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [5:0]  op;
    logic        ill;
    logic [31:0] pc;
  } ent_t;

  function automatic ent_t ref_decode(input logic [31:0] i, input logic [31:0] p);
    ent_t    e;
    opcode_e rtab[8], itab[8], ltab[8], stab[8], btab[8];
    opcode_e opc = OP_ILLEGAL;
    int      f3  = int'(i[14:12]);
    logic    ok  = 1'b1, ur = 1'b0, ut = 1'b0, ud = 1'b0;
    logic [31:0] iimm, simm, bimm, jimm, imm;
    rtab = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
    itab = '{OP_ADDI, OP_SLLI, OP_SLTI, OP_SLTIU, OP_XORI, OP_SRLI, OP_ORI, OP_ANDI};
    ltab = '{OP_LB, OP_LH, OP_LW, OP_ILLEGAL, OP_LBU, OP_LHU, OP_ILLEGAL, OP_ILLEGAL};
    stab = '{OP_SB, OP_SH, OP_SW, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL, OP_ILLEGAL};
    btab = '{OP_BEQ, OP_BNE, OP_ILLEGAL, OP_ILLEGAL, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    // immediates by plain weighted-bit arithmetic (sign bit has negative weight)
    iimm = (i[31] ? -32'd2048 : 32'd0) + 32'(i[30:20]);
    simm = (i[31] ? -32'd2048 : 32'd0) + 32'(i[30:25]) * 32 + 32'(i[11:7]);
    bimm = (i[31] ? -32'd4096 : 32'd0) + 32'(i[7]) * 2048 + 32'(i[30:25]) * 32 + 32'(i[11:8]) * 2;
    jimm = (i[31] ? -32'd1048576 : 32'd0) + 32'(i[19:12]) * 4096 + 32'(i[20]) * 2048
           + 32'(i[30:21]) * 2;
    imm = 32'd0;
    case (i[6:0])
      7'h33: begin
        opc = rtab[f3];
        if (i[30] && f3 == 0) opc = OP_SUB;
        if (i[30] && f3 == 5) opc = OP_SRA;
        ok = (i[31:25] == 7'h00) || (i[31:25] == 7'h20);
        ur = 1; ut = 1; ud = 1;
      end
      7'h13: begin
        opc = itab[f3];
        if (f3 == 5 && i[30]) opc = OP_SRAI;
        imm = (f3 == 1 || f3 == 5) ? 32'(i[24:20]) : iimm;
        ur = 1; ud = 1;
      end
      7'h03: begin opc = ltab[f3]; imm = iimm; ur = 1; ud = 1; end
      7'h67: begin opc = (f3 == 0) ? OP_JALR : OP_ILLEGAL; imm = iimm; ur = 1; ud = 1; end
      7'h23: begin opc = stab[f3]; imm = simm; ur = 1; ut = 1; end
      7'h63: begin opc = btab[f3]; imm = bimm; ur = 1; ut = 1; end
      7'h6F: begin opc = OP_JAL; imm = jimm; ud = 1; end
      7'h17: begin opc = OP_AUIPC; imm = i & 32'hFFFF_F000; ud = 1; end
      7'h37: begin opc = OP_LUI;   imm = i & 32'hFFFF_F000; ud = 1; end
      default: opc = OP_ILLEGAL;
    endcase
    e.pc = p;
    if (opc == OP_ILLEGAL || !ok) begin
      e.op = 6'd0; e.ill = 1'b1; e.imm = '0; e.rs = '0; e.rt = '0; e.rd = '0;
    end else begin
      e.op  = opc;
      e.ill = 1'b0;
      e.imm = imm;
      e.rs  = ur ? i[19:15] : 5'd0;
      e.rt  = ut ? i[24:20] : 5'd0;
      e.rd  = ud ? i[11:7]  : 5'd0;
    end
    return e;
  endfunction

  ent_t        mq[$];
  ent_t        m_new, h;
  logic        m_bp_en = 1'b0, m_if_en = 1'b0;
  logic [31:0] m_bp_pc = '0, m_if_addr = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_bp_en = 0; m_if_en = 0; m_bp_pc = '0; m_if_addr = '0;
    end else begin
      m_bp_en = 0;
      m_if_en = 0;
      if (rdy) begin
        if (flush) mq.delete();
        else begin
          logic do_push;
          do_push = iq_valid && (mq.size() < DEPTH);
          if (mq.size() > 0 && rs_ready) void'(mq.pop_front());
          if (do_push) begin
            m_new = ref_decode(inst, pc);
            mq.push_back(m_new);
            if (inst[6:0] == 7'h63 && !m_new.ill) begin m_bp_en = 1; m_bp_pc = pc; end
            if (inst[6:0] == 7'h6F) begin m_if_en = 1; m_if_addr = pc + m_new.imm; end
          end
        end
      end
    end
  end

  // Compare process: mid-cycle, every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("iq_ready", iq_ready, (mq.size() < DEPTH));
      chk("rs_valid", rs_valid, (mq.size() > 0));
      if (mq.size() > 0) begin
        h = mq[0];
        chk("rs_rs", rs_rs, h.rs);
        chk("rs_rt", rs_rt, h.rt);
        chk("rs_rd", rs_rd, h.rd);
        chk("rs_imm", rs_imm, h.imm);
        chk("rs_opcode", rs_opcode, h.op);
        chk("rs_pc", rs_pc, h.pc);
        chk("rs_illegal", rs_illegal, h.ill);
      end
      chk("bp_en", bp_en, m_bp_en && rdy);
      chk("bp_pc", bp_pc, m_bp_pc);
      chk("if_en", if_en, m_if_en && rdy);
      chk("if_addr", if_addr, m_if_addr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] p);
    iq_valid = 1'b1;
    inst     = i;
    pc       = p;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  majors[10];
    int          k;
    majors = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h17, 7'h37, 7'h7F};
    r = $urandom;
    k = $urandom_range(0, 10);
    if (k < 10) r[6:0] = majors[k];
    if (r[6:0] == 7'h33 && $urandom_range(0, 3) != 0) r[31:25] = r[30] ? 7'h20 : 7'h00;
    return r;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst_rs_valid", rs_valid, 1'b0);
    chk("rst_iq_ready", iq_ready, 1'b1);
    chk("rst_bp_en", bp_en, 1'b0);
    chk("rst_if_en", if_en, 1'b0);
    chk("rst_rs_pc", rs_pc, 32'h0);
    chk("rst_rs_imm", rs_imm, 32'h0);
    chk("rst_bp_pc", bp_pc, 32'h0);
    chk("rst_if_addr", if_addr, 32'h0);
    rst = 1'b0;

    // ADD x3,x1,x2
    rs_ready = 1'b1;
    offer(32'h002081B3, 32'h0);
    step();
    chk("t1_valid", rs_valid, 1'b1);
    chk("t1_op", rs_opcode, OP_ADD);
    chk("t1_rs", rs_rs, 5'd1);
    chk("t1_rt", rs_rt, 5'd2);
    chk("t1_rd", rs_rd, 5'd3);
    chk("t1_imm", rs_imm, 32'h0);
    chk("t1_ill", rs_illegal, 1'b0);

    // ADDI x1,x0,-1 then SRAI x1,x2,4
    offer(32'hFFF00093, 32'h4);
    step();
    chk("t2_imm", rs_imm, 32'hFFFF_FFFF);
    chk("t2_rs", rs_rs, 5'd0);
    chk("t2_rd", rs_rd, 5'd1);
    chk("t2_op", rs_opcode, OP_ADDI);
    offer(32'h40415093, 32'h8);
    step();
    chk("t2_srai_op", rs_opcode, OP_SRAI);
    chk("t2_srai_imm", rs_imm, 32'd4);
    chk("t2_srai_rs", rs_rs, 5'd2);

    // JAL x1,+8 @0x100, then BEQ +8 @0x200
    offer(32'h008000EF, 32'h100);
    step();
    chk("t3_if_en", if_en, 1'b1);
    chk("t3_if_addr", if_addr, 32'h108);
    chk("t3_jal_rd", rs_rd, 5'd1);
    chk("t3_jal_op", rs_opcode, OP_JAL);
    offer(32'h00000463, 32'h200);
    step();
    chk("t3_if_en_once", if_en, 1'b0);
    chk("t3_bp_en", bp_en, 1'b1);
    chk("t3_bp_pc", bp_pc, 32'h200);
    chk("t3_beq_imm", rs_imm, 32'd8);
    iq_valid = 1'b0;
    step();
    chk("t3_bp_once", bp_en, 1'b0);
    chk("t3_bp_pc_hold", bp_pc, 32'h200);
    chk("t3_if_addr_hold", if_addr, 32'h108);

    // backpressure: accept 2 of 3, then drain in order
    rs_ready = 1'b0;
    offer(32'h00000293, 32'h10); step();
    offer(32'h00000313, 32'h14); step();
    chk("t4_full_ready", iq_ready, 1'b0);
    offer(32'h00000393, 32'h18); step();
    chk("t4_still_full", iq_ready, 1'b0);
    chk("t4_head_a", rs_rd, 5'd5);
    rs_ready = 1'b1;
    step();
    chk("t4_head_b", rs_rd, 5'd6);
    step();
    chk("t4_head_c", rs_rd, 5'd7);
    iq_valid = 1'b0;
    step();
    chk("t4_empty", rs_valid, 1'b0);

    // flush with two entries and a JAL offered
    rs_ready = 1'b0;
    offer(32'h00000293, 32'h20); step();
    offer(32'h00000313, 32'h24); step();
    flush = 1'b1;
    offer(32'h008000EF, 32'h300);
    step();
    flush = 1'b0;
    iq_valid = 1'b0;
    chk("t5_valid", rs_valid, 1'b0);
    chk("t5_if_en", if_en, 1'b0);
    chk("t5_ready", iq_ready, 1'b1);
    chk("t5_if_addr", if_addr, 32'h108);

    // freeze with live traffic (including a flush request)
    offer(32'h00000293, 32'h30); step();
    rdy = 1'b0;
    rs_ready = 1'b1;
    offer(32'h008000EF, 32'h34);
    for (int k = 0; k < 5; k++) begin
      flush = (k == 2);
      step();
      chk("t6_frz_valid", rs_valid, 1'b1);
      chk("t6_frz_rd", rs_rd, 5'd5);
      chk("t6_frz_pc", rs_pc, 32'h30);
      chk("t6_frz_ifen", if_en, 1'b0);
    end
    flush = 1'b0;
    rdy = 1'b1;
    offer(32'h0000007F, 32'h400);
    step();
    chk("t6_ill", rs_illegal, 1'b1);
    chk("t6_ill_op", rs_opcode, 6'd0);
    chk("t6_ill_rd", rs_rd, 5'd0);
    chk("t6_ill_pc", rs_pc, 32'h400);
    iq_valid = 1'b0;
    rs_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_arst_valid", rs_valid, 1'b0);
    chk("t6_arst_ill", rs_illegal, 1'b0);
    chk("t6_arst_pc", rs_pc, 32'h0);
    chk("t6_arst_ifaddr", if_addr, 32'h0);
    step();
    rst = 1'b0;

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rdy      = ($urandom_range(0, 7) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      iq_valid = ($urandom_range(0, 3) != 0);
      rs_ready = $urandom_range(0, 1) == 1;
      inst     = rand_inst();
      pc       = $urandom & 32'hFFFF_FFFC;
      step();
    end
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
